// File: rtl/cache_refill_if.sv
// Processor, cache and main-memory signals of the cache refill controller.
// The controller connects through the master modport; the environment uses slave.
interface cache_refill_if #(
    parameter int WORDS = 16,
    parameter int SIZE  = 32
);
    logic                    cpu_req;
    logic [31:0]             address;
    logic                    hit;
    logic                    cache_read;
    logic [WORDS*SIZE-1:0]   block_out;
    logic                    mem_rd;
    logic [31:0]             mem_addr;
    logic [SIZE-1:0]         mem_data;
    logic                    mem_ready;
    logic                    stall;
    logic [15:0]             refill_count;

    modport master (
        input  cpu_req, address, hit, mem_data, mem_ready,
        output cache_read, block_out, mem_rd, mem_addr, stall, refill_count
    );

    modport slave (
        output cpu_req, address, hit, mem_data, mem_ready,
        input  cache_read, block_out, mem_rd, mem_addr, stall, refill_count
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: fetches a missed line word by word, then commands one fill.
// Define CRITICAL_WORD_FIRST_EN to start fetching at the missed word instead of word 0.
//
//   state | meaning
//   IDLE  | cache serves reads; a miss latches the line base and starts a refill
//   FETCH | one memory word read outstanding; each mem_ready edge stores a word
//   FILL  | single cycle writing the assembled line into the cache (cache_read=0)
module cache_refill_ctrl #(
    parameter int WORDS = 16,
    parameter int SIZE  = 32
) (
    input  logic           clk,
    input  logic           rst,
    cache_refill_if.master bus
);
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]            state_q;
    logic [31-IW:0]        base_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         wcnt_q;
    logic [WORDS*SIZE-1:0] block_q;
    logic [15:0]           count_q;
    logic [IW-1:0]         start_idx;
    logic                  miss;

    assign miss = bus.cpu_req && !bus.hit;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = bus.address[IW-1:0];
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            block_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        base_q  <= bus.address[31:IW];
                        idx_q   <= start_idx;
                        wcnt_q  <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        // idx always matches the low address bits, so words land in natural order
                        block_q[idx_q*SIZE +: SIZE] <= bus.mem_data;
                        idx_q  <= idx_q + 1'b1;
                        wcnt_q <= wcnt_q + 1'b1;
                        if (wcnt_q == LAST_WORD) begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cache_read   = (state_q != FILL);
    assign bus.mem_rd       = (state_q == FETCH);
    assign bus.stall        = (state_q != IDLE);
    assign bus.mem_addr     = {base_q, idx_q};
    assign bus.block_out    = block_q;
    assign bus.refill_count = count_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus queues expected lines and word
// addresses; a negedge monitor plays main memory and checks everything the DUT presents.
module tb_cache_refill_ctrl;
    localparam int WORDS = 16;
    localparam int SIZE  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_refill_if #(.WORDS(WORDS), .SIZE(SIZE)) bus();

    cache_refill_ctrl #(.WORDS(WORDS), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] mult;
        logic [31:0] salt;
        int          mode;
        int          miss_cyc;
    } line_t;

    line_t        lines[$];
    logic [31:0]  addr_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           fills_seen = 0;
    int           acc_cur = 0;
    int           last_acc = 0;
    logic [15:0]  cnt_exp = 16'h0;
    logic [511:0] last_line = '0;
    bit           pending_inc = 1'b0;

    // memory content is a per-refill affine scramble of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] m,
                                             input logic [31:0] s);
        return (a * m) ^ s;
    endfunction

    function automatic logic [511:0] line_data(input line_t e);
        logic [511:0] blk;
        blk = '0;
        for (int k = 0; k < 16; k++) begin
            blk[k*32 +: 32] = mem_word(e.base + 32'(k), e.mult, e.salt);
        end
        return blk;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor + main-memory model
    initial begin
        line_t e;
        bit    rdy;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            bus.mem_data = $urandom;
            if (rst) begin
                pending_inc = 1'b0;
            end else begin
                if (pending_inc) begin
                    if (cnt_exp != 16'hFFFF) cnt_exp++;
                    pending_inc = 1'b0;
                end
                chk("refill_count", bus.refill_count, cnt_exp);
                if (lines.size() == 0) begin
                    chk("idle_rd_stall_cread", {bus.mem_rd, bus.stall, bus.cache_read}, 3'b001);
                    chk("block_hold", bus.block_out, last_line);
                end else begin
                    e = lines[0];
                    case (e.mode)
                        0:       rdy = 1'b1;
                        1:       rdy = (cyc % 3 == 0);
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    if (!bus.cache_read) begin
                        chk("fill_rd_stall", {bus.mem_rd, bus.stall}, 2'b01);
                        chk("fill_words_left", addr_q.size(), 0);
                        chk("fill_timing", cyc, last_acc + 1);
                        if (e.mode == 0) chk("fill_latency", cyc - e.miss_cyc, 16);
                        chk("fill_line", bus.block_out, line_data(e));
                        last_line = line_data(e);
                        void'(lines.pop_front());
                        pending_inc = 1'b1;
                        fills_seen++;
                    end else if (bus.mem_rd) begin
                        chk("fetch_stall", bus.stall, 1'b1);
                        chk("fetch_pending", (addr_q.size() != 0), 1'b1);
                        if (addr_q.size() != 0) begin
                            chk("mem_addr", bus.mem_addr, addr_q[0]);
                            if (rdy) begin
                                void'(addr_q.pop_front());
                                last_acc = cyc;
                                acc_cur++;
                            end
                        end
                        bus.mem_data = mem_word(bus.mem_addr, e.mult, e.salt);
                    end else begin
                        chk("fetch_start", cyc, e.miss_cyc - 1);
                    end
                end
            end
            bus.mem_ready = rdy;
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("reset_cread_rd_stall", {bus.cache_read, bus.mem_rd, bus.stall}, 3'b100);
        chk("reset_mem_addr", bus.mem_addr, 32'h0);
        chk("reset_block_out", bus.block_out, '0);
        chk("reset_refill_count", bus.refill_count, 16'h0);
        lines.delete();
        addr_q.delete();
        cnt_exp     = 16'h0;
        last_line   = '0;
        pending_inc = 1'b0;
        bus.cpu_req = 1'b0;
        bus.hit     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            case ($urandom_range(0, 2))
                0:       begin bus.cpu_req = 1'b1; bus.hit = 1'b1; end
                1:       begin bus.cpu_req = 1'b0; bus.hit = 1'b0; end
                default: begin bus.cpu_req = 1'b0; bus.hit = 1'b1; end
            endcase
            bus.address = $urandom;
        end
    endtask

    task automatic refill(input logic [31:0] a, input int mode, input logic [31:0] m,
                          input logic [31:0] s, input int abort_at);
        line_t e;
        int    f0;
        int    st;
        @(posedge clk);
        #2;
        e.base     = {a[31:4], 4'h0};
        e.mult     = m;
        e.salt     = s;
        e.mode     = mode;
        e.miss_cyc = cyc + 1;
`ifdef CRITICAL_WORD_FIRST_EN
        st = int'(a[3:0]);
`else
        st = 0;
`endif
        lines.push_back(e);
        for (int i = 0; i < 16; i++) addr_q.push_back(e.base + 32'((st + i) % 16));
        acc_cur     = 0;
        f0          = fills_seen;
        bus.cpu_req = 1'b1;
        bus.hit     = 1'b0;
        bus.address = a;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (fills_seen != f0) begin
                bus.cpu_req = 1'b0;
                bus.hit     = 1'b0;
                return;
            end
            if (abort_at >= 0 && acc_cur >= abort_at) begin
                apply_reset();
                return;
            end
            bus.cpu_req = 1'($urandom);
            bus.hit     = 1'($urandom);
            bus.address = $urandom;
        end
        checks++;
        errors++;
        $display("FAIL refill_timeout: got no fill, expected one within 200 cycles");
        apply_reset();
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.hit     = 1'b0;
        bus.address = '0;
        repeat (2) @(posedge clk);
        #2;
        apply_reset();
        idle_noise(12);
        refill(32'h0000_1234, 0, 32'h1, 32'h0, -1);
        idle_noise(3);
        refill($urandom, 1, $urandom | 32'h1, $urandom, -1);
        for (int i = 0; i < 8; i++) begin
            idle_noise($urandom_range(0, 3));
            refill($urandom, $urandom_range(0, 2), $urandom, $urandom, -1);
        end
        refill($urandom, 0, 32'h1, 32'h0, 5);
        idle_noise(10);
        @(posedge clk);
        #2;
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        cnt_exp = 16'hFFFE;
        refill($urandom, 2, $urandom, $urandom, -1);
        refill($urandom, 0, $urandom, $urandom, -1);
        idle_noise(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
